eth_link_failover: RTL and testbench

//  Parametrised Ethernet PHY link selector with failover. Watches N_PORTS

---
 rtl/eth_link_failover.sv | 169 ++++++++++++++++
 tb/tb_eth_link_failover.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_link_failover.sv
// eth_link_failover: picks one of N_PORTS PHY links for the RMII/MII data mux.
// Raw link pins are synchronised and debounced. A small FSM then chooses the
// port, with sticky or revertive failover, a post-switch guard time and a
// manual override. All outputs are registered.
module eth_link_failover #(
  parameter int N_PORTS         = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int GUARD_CYCLES    = 16,
  parameter int REVERTIVE       = 0,
  parameter int DEFAULT_PORT    = 0,
  localparam int SEL_W          = $clog2(N_PORTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] link_in,
  input  logic               force_en,
  input  logic [SEL_W-1:0]   force_sel,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               led,
  output logic               switch_pulse,
  output logic [N_PORTS-1:0] link_ok
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [DW-1:0]    D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0]    G_LAST  = GW'(GUARD_CYCLES - 1);
  localparam logic [SEL_W:0]   N_LIM   = (SEL_W + 1)'(N_PORTS);
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_PORT);

  // NO_LINK: nothing usable; ACTIVE: normal; GUARD: just switched, no reverting
  typedef enum logic [1:0] {NO_LINK, ACTIVE, GUARD} state_t;

  state_t             state;
  logic [N_PORTS-1:0] sync1;
  logic [N_PORTS-1:0] sync2;
  logic [DW-1:0]      db_cnt [N_PORTS];
  logic [GW-1:0]      guard_cnt;
  logic [SEL_W-1:0]   best;
  logic               sel_ok;
  logic               force_ok;
  logic               any_ok;
  logic               force_act;

  // Two-flop synchroniser for the asynchronous link pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= link_in;
      sync2 <= sync1;
    end
  end

  // Per-port debounce: the state flips only after DEBOUNCE_CYCLES disagreeing clocks in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_ok <= '0;
      for (int i = 0; i < N_PORTS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (sync2[i] == link_ok[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == D_LAST) begin
          db_cnt[i]  <= '0;
          link_ok[i] <= ~link_ok[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest healthy port, plus link state of the current and the forced port
  always_comb begin
    best     = '0;
    sel_ok   = 1'b0;
    force_ok = 1'b0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (link_ok[i]) best = SEL_W'(i);
      if (sel == SEL_W'(i)) sel_ok = link_ok[i];
      if (force_sel == SEL_W'(i)) force_ok = link_ok[i];
    end
  end

  assign any_ok    = |link_ok;
  // An out-of-range manual choice is ignored rather than selecting a phantom port
  assign force_act = force_en && ({1'b0, force_sel} < N_LIM);

  // Selection FSM with registered sel / sel_valid / led / switch_pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= NO_LINK;
      sel          <= DEF_SEL;
      sel_valid    <= 1'b0;
      led          <= 1'b0;
      switch_pulse <= 1'b0;
      guard_cnt    <= '0;
    end else begin
      switch_pulse <= 1'b0;
      if (force_act) begin
        // Override wins; leaving it resumes from this sel without a guard
        sel          <= force_sel;
        switch_pulse <= (force_sel != sel);
        sel_valid    <= force_ok;
        led          <= force_ok;
        guard_cnt    <= '0;
        state        <= force_ok ? ACTIVE : NO_LINK;
      end else begin
        case (state)
          NO_LINK: begin
            if (any_ok) begin
              sel       <= best;
              sel_valid <= 1'b1;
              led       <= 1'b1;
              if (best != sel) begin
                switch_pulse <= 1'b1;
                guard_cnt    <= '0;
                state        <= GUARD;
              end else begin
                state <= ACTIVE;
              end
            end else begin
              sel_valid <= 1'b0;
              led       <= 1'b0;
            end
          end
          default: begin
            // ACTIVE and GUARD share the loss-of-link failover
            if (!sel_ok) begin
              if (any_ok) begin
                sel          <= best;
                switch_pulse <= 1'b1;
                sel_valid    <= 1'b1;
                led          <= 1'b1;
                guard_cnt    <= '0;
                state        <= GUARD;
              end else begin
                sel_valid <= 1'b0;
                led       <= 1'b0;
                state     <= NO_LINK;
              end
            end else if (state == ACTIVE) begin
              sel_valid <= 1'b1;
              led       <= 1'b1;
              if ((REVERTIVE != 0) && (best < sel)) begin
                sel          <= best;
                switch_pulse <= 1'b1;
                guard_cnt    <= '0;
                state        <= GUARD;
              end
            end else begin
              sel_valid <= 1'b1;
              led       <= 1'b1;
              if (guard_cnt == G_LAST) begin
                state <= ACTIVE;
              end else begin
                guard_cnt <= guard_cnt + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_link_failover.sv
// Bench for eth_link_failover: a sticky and a revertive 4-port instance share
// stimulus and are checked every clock against a cycle-stamped reference
// model; a 5-port instance exercises the out-of-range override.
module tb_eth_link_failover;

  localparam int DEB   = 8;
  localparam int GRD   = 16;
  localparam int NEVER = -100000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] link_in = '0;
  logic       force_en = 1'b0;
  logic [1:0] force_sel = '0;

  logic [1:0] sel_s, sel_r;
  logic       valid_s, led_s, pulse_s, valid_r, led_r, pulse_r;
  logic [3:0] ok_s, ok_r;

  logic [4:0] link5 = '0;
  logic       fe5 = 1'b0;
  logic [2:0] fs5 = '0;
  logic [2:0] sel5;
  logic       v5, led5, p5;
  logic [4:0] ok5;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int         cyc;
  logic [3:0] hist [0:8191];
  logic [3:0] m_ok;
  int         last_tog [4];
  logic [1:0] m_sel [2];
  logic       m_valid [2];
  logic       m_pulse [2];
  int         m_gs [2];
  logic [17:0] exp_vec;
  logic [17:0] dut_vec;

  assign dut_vec = {sel_s, valid_s, led_s, pulse_s, ok_s, sel_r, valid_r, led_r, pulse_r, ok_r};

  always #5 clk = ~clk;

  eth_link_failover #(.N_PORTS(4), .DEBOUNCE_CYCLES(DEB), .GUARD_CYCLES(GRD),
                      .REVERTIVE(0), .DEFAULT_PORT(0)) u_sticky (
    .clk(clk), .rst(rst), .link_in(link_in), .force_en(force_en), .force_sel(force_sel),
    .sel(sel_s), .sel_valid(valid_s), .led(led_s), .switch_pulse(pulse_s), .link_ok(ok_s));

  eth_link_failover #(.N_PORTS(4), .DEBOUNCE_CYCLES(DEB), .GUARD_CYCLES(GRD),
                      .REVERTIVE(1), .DEFAULT_PORT(0)) u_rev (
    .clk(clk), .rst(rst), .link_in(link_in), .force_en(force_en), .force_sel(force_sel),
    .sel(sel_r), .sel_valid(valid_r), .led(led_r), .switch_pulse(pulse_r), .link_ok(ok_r));

  eth_link_failover #(.N_PORTS(5), .DEBOUNCE_CYCLES(DEB), .GUARD_CYCLES(GRD),
                      .REVERTIVE(0), .DEFAULT_PORT(0)) u_five (
    .clk(clk), .rst(rst), .link_in(link5), .force_en(fe5), .force_sel(fs5),
    .sel(sel5), .sel_valid(v5), .led(led5), .switch_pulse(p5), .link_ok(ok5));

  // ---------------- reference model ----------------
  function automatic logic [3:0] hval(int k);
    if (k >= 1) return hist[k];
    return 4'b0000;
  endfunction

  task automatic model_reset();
    cyc  = 0;
    m_ok = '0;
    for (int i = 0; i < 4; i++) last_tog[i] = 0;
    for (int r = 0; r < 2; r++) begin
      m_sel[r] = '0; m_valid[r] = 1'b0; m_pulse[r] = 1'b0; m_gs[r] = NEVER;
    end
    exp_vec = '0;
  endtask

  // One clock edge of the intended behaviour, driven by cycle timestamps
  task automatic model_step();
    logic [3:0] ok_old, hv;
    int best, s, ns;
    bit match;
    ok_old = m_ok;
    best = -1;
    for (int i = 3; i >= 0; i--) if (ok_old[i]) best = i;
    for (int r = 0; r < 2; r++) begin
      s = int'(m_sel[r]);
      ns = s;
      if (force_en) begin
        ns = int'(force_sel); m_gs[r] = NEVER;
      end else if (!m_valid[r]) begin
        if (best >= 0) begin ns = best; m_gs[r] = (ns != s) ? cyc : NEVER; end
      end else if (!ok_old[s]) begin
        if (best >= 0) begin ns = best; m_gs[r] = cyc; end
      end else if (r == 1 && best < s && cyc > m_gs[r] + GRD) begin
        ns = best; m_gs[r] = cyc;
      end
      m_pulse[r] = (ns != s);
      m_sel[r]   = 2'(ns);
      m_valid[r] = ok_old[ns];
    end
    // link_ok flips when the pin, seen two clocks late, has disagreed for DEB edges since the last flip
    for (int i = 0; i < 4; i++) begin
      if (cyc - DEB + 1 > last_tog[i]) begin
        match = 1'b1;
        for (int j = cyc - DEB + 1; j <= cyc; j++) begin
          hv = hval(j - 2);
          if (hv[i] == ok_old[i]) match = 1'b0;
        end
        if (match) begin m_ok[i] = ~ok_old[i]; last_tog[i] = cyc; end
      end
    end
    exp_vec = {m_sel[0], m_valid[0], m_valid[0], m_pulse[0], m_ok,
               m_sel[1], m_valid[1], m_valid[1], m_pulse[1], m_ok};
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    hist[cyc] = link_in;
    #1;
  endtask

  task automatic assert_rst();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    assert_rst();
    n_cmp++;
    if ({dut_vec, sel5, v5, led5, p5, ok5} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset_values got=%h exp=0", {dut_vec, sel5, v5, led5, p5, ok5});
    end
    release_rst();
    repeat (4) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL idle_after_reset cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_link_up();
    int t0, first_ok, first_p, np;
    @(negedge clk);
    link_in = 4'b0010;
    t0 = cyc; first_ok = -1; first_p = -1; np = 0;
    repeat (14) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL link_up cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
      if (ok_s[1] && first_ok < 0) first_ok = cyc - t0;
      if (pulse_s) begin np++; if (first_p < 0) first_p = cyc - t0; end
    end
    n_cmp++;
    if (first_ok != 10) begin n_bad++; $display("FAIL link_up_latency got=%0d exp=10", first_ok); end
    n_cmp++;
    if (first_p != 11 || np != 1 || sel_s !== 2'd1 || led_s !== 1'b1) begin
      n_bad++; $display("FAIL link_up_select pulse_at=%0d pulses=%0d sel=%0d led=%b exp 11/1/1/1", first_p, np, sel_s, led_s);
    end
  endtask

  task automatic test_glitch();
    int np, chg, t0;
    np = 0; chg = 0;
    @(negedge clk);
    link_in = 4'b0000;
    repeat (7) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL glitch7 cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
      if (pulse_s || pulse_r) np++;
      if (ok_s !== 4'b0010) chg++;
    end
    @(negedge clk);
    link_in = 4'b0010;
    repeat (15) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL glitch7_after cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
      if (pulse_s || pulse_r) np++;
      if (ok_s !== 4'b0010 || valid_s !== 1'b1) chg++;
    end
    n_cmp++;
    if (np != 0 || chg != 0) begin n_bad++; $display("FAIL glitch7_no_effect pulses=%0d changes=%0d exp 0/0", np, chg); end
    // a 9-clock drop is long enough to take the only link down
    @(negedge clk);
    link_in = 4'b0000;
    t0 = cyc;
    while (cyc < t0 + 9) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL glitch9 cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
    end
    @(negedge clk);
    link_in = 4'b0010;
    while (cyc < t0 + 23) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL glitch9_after cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
      if (cyc == t0 + 15) begin
        n_cmp++;
        if (sel_s !== 2'd1 || valid_s !== 1'b0 || led_s !== 1'b0) begin
          n_bad++; $display("FAIL no_link_hold sel=%0d valid=%b led=%b exp 1/0/0", sel_s, valid_s, led_s);
        end
      end
    end
    n_cmp++;
    if (sel_s !== 2'd1 || valid_s !== 1'b1) begin n_bad++; $display("FAIL relink sel=%0d valid=%b exp 1/1", sel_s, valid_s); end
  endtask

  task automatic test_failover();
    int t0, e, np_s;
    @(negedge clk);
    link_in = 4'b0110;
    repeat (14) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL two_links cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
    end
    @(negedge clk);
    link_in = 4'b0100;
    t0 = cyc; e = t0 + 11; np_s = 0;
    while (cyc < e + 2) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL failover cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
      if (cyc == e) begin
        n_cmp++;
        if (sel_s !== 2'd2 || pulse_s !== 1'b1 || sel_r !== 2'd2 || pulse_r !== 1'b1) begin
          n_bad++; $display("FAIL failover_11clk sel_s=%0d p=%b sel_r=%0d p=%b exp 2/1/2/1", sel_s, pulse_s, sel_r, pulse_r);
        end
      end
    end
    // link 0 comes back during the guard window
    @(negedge clk);
    link_in = 4'b0101;
    while (cyc < e + 25) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL revert cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
      if (pulse_s) np_s++;
      if (cyc == e + 16) begin
        n_cmp++;
        if (sel_r !== 2'd2) begin n_bad++; $display("FAIL guard_blocks_revert sel_r=%0d exp 2", sel_r); end
      end
      if (cyc == e + 17) begin
        n_cmp++;
        if (sel_r !== 2'd0 || pulse_r !== 1'b1) begin n_bad++; $display("FAIL revert_after_guard sel_r=%0d p=%b exp 0/1", sel_r, pulse_r); end
      end
    end
    n_cmp++;
    if (sel_s !== 2'd2 || np_s != 0) begin n_bad++; $display("FAIL sticky_keeps sel_s=%0d pulses=%0d exp 2/0", sel_s, np_s); end
  endtask

  task automatic test_force();
    @(negedge clk);
    force_en = 1'b1; force_sel = 2'd3;
    repeat (4) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL force3 cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
    end
    n_cmp++;
    if (sel_s !== 2'd3 || sel_r !== 2'd3 || valid_s !== 1'b0 || led_s !== 1'b0 || led_r !== 1'b0) begin
      n_bad++; $display("FAIL force_down_link sel=%0d/%0d valid=%b led=%b/%b exp 3/3/0/0/0", sel_s, sel_r, valid_s, led_s, led_r);
    end
    @(negedge clk);
    force_sel = 2'd2;
    repeat (3) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL force2 cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
    end
    @(negedge clk);
    force_en = 1'b0;
    repeat (4) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL force_release cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
    end
    n_cmp++;
    if (sel_s !== 2'd2 || valid_s !== 1'b1 || sel_r !== 2'd0) begin
      n_bad++; $display("FAIL after_release sel_s=%0d valid=%b sel_r=%0d exp 2/1/0", sel_s, valid_s, sel_r);
    end
  endtask

  task automatic test_force_range();
    int bad, np;
    bad = 0; np = 0;
    @(negedge clk);
    fe5 = 1'b1; fs5 = 3'd7;
    repeat (6) begin
      tick();
      if (sel5 !== 3'd0 || p5 !== 1'b0 || v5 !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL force_out_of_range bad_cycles=%0d sel5=%0d exp 0 and sel5=0", bad, sel5); end
    @(negedge clk);
    fs5 = 3'd4;
    tick();
    n_cmp++;
    if (sel5 !== 3'd4 || p5 !== 1'b1 || v5 !== 1'b0) begin n_bad++; $display("FAIL force_port4 sel5=%0d p=%b v=%b exp 4/1/0", sel5, p5, v5); end
    tick();
    n_cmp++;
    if (p5 !== 1'b0) begin n_bad++; $display("FAIL force_pulse_width p=%b exp 0", p5); end
    @(negedge clk);
    fe5 = 1'b0;
    link5 = 5'b10000;
    repeat (12) begin
      tick();
      if (p5) np++;
    end
    n_cmp++;
    if (sel5 !== 3'd4 || v5 !== 1'b1 || led5 !== 1'b1 || ok5 !== 5'b10000 || np != 0) begin
      n_bad++; $display("FAIL five_relink sel5=%0d v=%b led=%b ok=%b pulses=%0d exp 4/1/1/10000/0", sel5, v5, led5, ok5, np);
    end
  endtask

  task automatic test_guard_reset();
    @(negedge clk);
    link_in = 4'b0100;
    repeat (16) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL pre_guard_reset cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
    end
    assert_rst();
    n_cmp++;
    if ({dut_vec, sel5, v5, led5, p5, ok5} !== 28'h0) begin
      n_bad++; $display("FAIL reset_mid_guard got=%h exp=0", {dut_vec, sel5, v5, led5, p5, ok5});
    end
    release_rst();
    repeat (14) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_random();
    int hold;
    repeat (100) begin
      @(negedge clk);
      link_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) force_en = ~force_en;
      force_sel = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 24);
      repeat (hold) begin
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
      end
    end
    @(negedge clk);
    force_en = 1'b0;
    repeat (30) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL random_tail cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_link_up();
    test_glitch();
    test_failover();
    test_force();
    test_force_range();
    test_guard_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
